// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and the multiply/divide unit:
// ALUOp and funct encodings, 4-bit operation codes, FSM states and the decoder.
package alu_ctrl_pkg;

    // ALUOp field driven by the main control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    // R-type funct field values understood by this unit
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    // 4-bit operation codes presented on the operation output
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_NOR     = 4'b1100;
    localparam logic [3:0] OP_MULTU   = 4'b1000;
    localparam logic [3:0] OP_DIVU    = 4'b1001;
    localparam logic [3:0] OP_MFHI    = 4'b1010;
    localparam logic [3:0] OP_MFLO    = 4'b1011;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // Execute-stage FSM: idle, or iterating a multiply or a divide
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Map ALUOp/funct to an operation code; anything unknown is ILLEGAL
    function automatic logic [3:0] decode_op(input logic [1:0] alu_op,
                                             input logic [5:0] funct);
        logic [3:0] op;
        op = OP_ILLEGAL;
        case (alu_op)
            ALUOP_ADD: op = OP_ADD;
            ALUOP_SUB: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: op = OP_ADD;
                    FUNCT_SUB, FUNCT_SUBU: op = OP_SUB;
                    FUNCT_AND:             op = OP_AND;
                    FUNCT_OR:              op = OP_OR;
                    FUNCT_NOR:             op = OP_NOR;
                    FUNCT_SLT:             op = OP_SLT;
                    FUNCT_MULTU:           op = OP_MULTU;
                    FUNCT_DIVU:            op = OP_DIVU;
                    FUNCT_MFHI:            op = OP_MFHI;
                    FUNCT_MFLO:            op = OP_MFLO;
                    default:               op = OP_ILLEGAL;
                endcase
            end
            default: op = OP_ILLEGAL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide datapath. One bit per cycle for WIDTH
// cycles after start; done flags the cycle whose closing edge completes the
// last iteration, with hi_out/lo_out carrying the final {hi,lo} value.
module mdu_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // acc holds {partial product, multiplier} for multiply and
    // {partial remainder, dividend/quotient} for divide.
    logic                 busy_q, busy_d;
    logic                 is_div_q, is_div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   iter_next;

    // One iteration step of both algorithms; the latched mode picks one
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
        iter_next = is_div_q ? div_next : mul_next;
        done      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        hi_out    = iter_next[2*WIDTH-1:WIDTH];
        lo_out    = iter_next[WIDTH-1:0];
    end

    // Load operands on start, otherwise advance one bit while busy
    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = '0;
            opnd_d   = is_div ? b : a;
            acc_d    = {{WIDTH{1'b0}}, (is_div ? a : b)};
        end else if (busy_q) begin
            acc_d = iter_next;
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Iteration state registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with a registered execute stage: single-cycle logic and
// arithmetic ops complete one cycle after accept, MULTU/DIVU run through the
// iterative unit and hold off new requests by dropping ready.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid,
    output logic             ready,
    output logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             result_valid,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             result_valid_q, result_valid_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             mdu_start;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_hi;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] alu_res;

    assign operation    = decode_op(alu_op, funct);
    assign ready        = (state_q == ST_IDLE);
    assign accept       = valid && ready;
    assign mdu_start    = accept && ((operation == OP_MULTU) || (operation == OP_DIVU));
    assign result       = result_q;
    assign zero         = zero_q;
    assign result_valid = result_valid_q;
    assign illegal      = illegal_q;
    assign hi           = hi_q;
    assign lo           = lo_q;

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .is_div (operation == OP_DIVU),
        .a      (a),
        .b      (b),
        .done   (mdu_done),
        .hi_out (mdu_hi),
        .lo_out (mdu_lo)
    );

    // Single-cycle result for the decoded operation
    always_comb begin
        alu_res = '0;
        case (operation)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  alu_res = ~(a | b);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // FSM and output register next-state; pulses default low every cycle
    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        zero_d         = zero_q;
        result_valid_d = 1'b0;
        illegal_d      = 1'b0;
        hi_d           = hi_q;
        lo_d           = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (operation)
                        OP_MULTU: state_d = ST_MUL;
                        OP_DIVU:  state_d = ST_DIV;
                        OP_ILLEGAL: begin
                            result_d       = '0;
                            zero_d         = 1'b1;
                            result_valid_d = 1'b1;
                            illegal_d      = 1'b1;
                        end
                        default: begin
                            result_d       = alu_res;
                            zero_d         = (alu_res == '0);
                            result_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdu_done) begin
                    hi_d           = mdu_hi;
                    lo_d           = mdu_lo;
                    result_d       = mdu_lo;
                    zero_d         = (mdu_lo == '0);
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            result_q       <= '0;
            zero_q         <= 1'b1;
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            zero_q         <= zero_d;
            result_valid_q <= result_valid_d;
            illegal_q      <= illegal_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu: a directed vector table, a reset
// abort sequence, then randomized requests against an arithmetic model.
module tb_alu_ctrl_mdu;

    localparam int W  = 32;
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  a, b;
    logic          valid;
    logic          ready;
    logic [3:0]    operation;
    logic [W-1:0]  result;
    logic          zero;
    logic          result_valid;
    logic          illegal;
    logic [W-1:0]  hi, lo;

    int            vec_count  = 0;
    int            miss_count = 0;
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;

    typedef struct {
        logic [1:0]   alu_op;
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   exp_op;
        logic [W-1:0] exp_res;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_ill;
        bit           hold;
    } vec_t;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_op       (alu_op),
        .funct        (funct),
        .a            (a),
        .b            (b),
        .valid        (valid),
        .ready        (ready),
        .operation    (operation),
        .result       (result),
        .zero         (zero),
        .result_valid (result_valid),
        .illegal      (illegal),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Operation code from the instruction-set table
    function automatic logic [3:0] model_op(input logic [1:0] op_sel, input logic [5:0] fn);
        if (op_sel == 2'b00) return 4'b0010;
        if (op_sel == 2'b01) return 4'b0110;
        if (op_sel == 2'b11) return 4'b1111;
        case (fn)
            6'b100000, 6'b100001: return 4'b0010;
            6'b100010, 6'b100011: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b100111: return 4'b1100;
            6'b101010: return 4'b0111;
            6'b011001: return 4'b1000;
            6'b011011: return 4'b1001;
            6'b010000: return 4'b1010;
            6'b010010: return 4'b1011;
            default:   return 4'b1111;
        endcase
    endfunction

    // Architectural effect of an operation, computed with plain arithmetic
    task automatic model_exec(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                              output logic [W-1:0] eres, output logic [W-1:0] ehi,
                              output logic [W-1:0] elo, output logic eill);
        longint unsigned prod;
        ehi  = m_hi;
        elo  = m_lo;
        eill = 1'b0;
        eres = '0;
        case (op)
            4'b0000: eres = aa & bb;
            4'b0001: eres = aa | bb;
            4'b0010: eres = aa + bb;
            4'b0110: eres = aa - bb;
            4'b0111: eres = ($signed(aa) < $signed(bb)) ? 32'd1 : 32'd0;
            4'b1100: eres = ~(aa | bb);
            4'b1010: eres = m_hi;
            4'b1011: eres = m_lo;
            4'b1000: begin
                prod = longint'(aa) * longint'(bb);
                ehi  = prod[63:32];
                elo  = prod[31:0];
                eres = elo;
            end
            4'b1001: begin
                if (bb == 0) begin
                    elo = '1;
                    ehi = aa;
                end else begin
                    elo = aa / bb;
                    ehi = aa % bb;
                end
                eres = elo;
            end
            default: eill = 1'b1;
        endcase
    endtask

    // Issue one request at a negedge and follow it to its result pulse
    task automatic apply_stimulus(input logic [1:0] op_sel, input logic [5:0] fn,
                                  input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic [3:0] eop, input logic [W-1:0] eres,
                                  input logic [W-1:0] ehi, input logic [W-1:0] elo,
                                  input logic eill, input bit hold, input bit gap, input string tag);
        int lat;
        int rdy_low;
        int elat;
        bit hilo_ok;
        elat   = (eop == 4'b1000 || eop == 4'b1001) ? W + 1 : 1;
        alu_op = op_sel;
        funct  = fn;
        a      = aa;
        b      = bb;
        valid  = 1'b1;
        #1;
        check_output({tag, ".operation"}, 64'(operation), 64'(eop));
        check_output({tag, ".ready_at_issue"}, 64'(ready), 64'd1);
        @(posedge clk);
        lat     = 0;
        rdy_low = 0;
        hilo_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!ready) rdy_low++;
            if (!result_valid && (hi !== m_hi || lo !== m_lo)) hilo_ok = 1'b0;
            if (!hold || result_valid) valid = 1'b0;
        end while (!result_valid && lat < 3 * W);
        valid = 1'b0;
        check_output({tag, ".latency"}, 64'(lat), 64'(elat));
        check_output({tag, ".ready_low_cycles"}, 64'(rdy_low), 64'(elat - 1));
        check_output({tag, ".result"}, 64'(result), 64'(eres));
        check_output({tag, ".zero"}, 64'(zero), 64'(eres == 0));
        check_output({tag, ".illegal"}, 64'(illegal), 64'(eill));
        check_output({tag, ".hi"}, 64'(hi), 64'(ehi));
        check_output({tag, ".lo"}, 64'(lo), 64'(elo));
        check_output({tag, ".hilo_hold_busy"}, 64'(hilo_ok), 64'd1);
        m_hi = ehi;
        m_lo = elo;
        if (gap) begin
            @(negedge clk);
            check_output({tag, ".pulse_width"}, 64'({result_valid, illegal}), 64'd0);
            check_output({tag, ".ready_after"}, 64'(ready), 64'd1);
        end
    endtask

    logic [5:0] fn_list [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                 6'b100111, 6'b101010, 6'b011001, 6'b011011, 6'b010000, 6'b010010};

    initial begin
        logic [1:0]   r_op;
        logic [5:0]   r_fn;
        logic [W-1:0] r_a, r_b, eres, ehi, elo;
        logic [3:0]   eop;
        logic         eill;
        bit           seen;
        int           kind;

        tbl[0]  = '{2'b10, 6'b100010, 32'd5, 32'd5, 4'b0110, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 4'b0111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0};
        tbl[3]  = '{2'b10, 6'b011001, 32'hFFFFFFFF, 32'd2, 4'b1000, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, 6'b011011, 32'd100, 32'd7, 4'b1001, 32'd14, 32'd2, 32'd14, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 6'b011011, 32'h1234, 32'd0, 4'b1001, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 6'b010000, 32'd0, 32'd0, 4'b1010, 32'h1234, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 6'b000000, 32'd3, 32'd4, 4'b1111, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 6'b100000, 32'd3, 32'd4, 4'b1111, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 6'b111111, 32'hFFFFFFFF, 32'd2, 4'b0010, 32'd1, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 6'b000000, 32'd0, 32'd1, 4'b0110, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[11] = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[13] = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 32'h000F000F, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[14] = '{2'b10, 6'b100001, 32'h80000000, 32'h80000000, 4'b0010, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[15] = '{2'b10, 6'b100011, 32'd16, 32'd3, 4'b0110, 32'd13, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[16] = '{2'b10, 6'b010010, 32'd0, 32'd0, 4'b1011, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[17] = '{2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 4'b0111, 32'd1, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[18] = '{2'b10, 6'b101010, 32'd5, 32'd5, 4'b0111, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[19] = '{2'b10, 6'b011001, 32'd7, 32'd6, 4'b1000, 32'd42, 32'd0, 32'd42, 1'b0, 1'b0};
        tbl[20] = '{2'b10, 6'b011011, 32'hFFFFFFFF, 32'd1, 4'b1001, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0};

        alu_op = 2'b00;
        funct  = 6'b000000;
        a      = '0;
        b      = '0;
        valid  = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_output("reset.ready", 64'(ready), 64'd1);
        check_output("reset.result", 64'(result), 64'd0);
        check_output("reset.zero", 64'(zero), 64'd1);
        check_output("reset.pulses", 64'({result_valid, illegal}), 64'd0);
        check_output("reset.hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table; every third entry issues back-to-back with the next
        for (int i = 0; i < NV; i++) begin
            apply_stimulus(tbl[i].alu_op, tbl[i].funct, tbl[i].a, tbl[i].b, tbl[i].exp_op,
                           tbl[i].exp_res, tbl[i].exp_hi, tbl[i].exp_lo, tbl[i].exp_ill,
                           tbl[i].hold, (i % 3) != 2, $sformatf("vec%0d", i));
        end
        @(negedge clk);

        // Reset in the middle of a multiply aborts it without a pulse
        alu_op = 2'b10;
        funct  = 6'b011001;
        a      = 32'd7;
        b      = 32'd6;
        valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        check_output("abort.busy_before", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_output("abort.ready", 64'(ready), 64'd1);
        check_output("abort.hilo", {hi, lo}, 64'd0);
        check_output("abort.result_valid", 64'(result_valid), 64'd0);
        check_output("abort.result", 64'(result), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_hi  = '0;
        m_lo  = '0;
        seen  = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (result_valid) seen = 1'b1;
        end
        check_output("abort.no_pulse", 64'(seen), 64'd0);
        apply_stimulus(2'b10, 6'b010010, 32'd9, 32'd9, 4'b1011, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "abort.mflo");

        // Randomized requests checked against the arithmetic model
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 11);
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
            if (kind == 0)      begin r_op = 2'b00; r_fn = 6'($urandom); end
            else if (kind == 1) begin r_op = 2'b01; r_fn = 6'($urandom); end
            else if (kind == 2) begin r_op = 2'b11; r_fn = 6'($urandom); end
            else if (kind == 3) begin r_op = 2'b10; r_fn = 6'($urandom); end
            else                begin r_op = 2'b10; r_fn = fn_list[$urandom_range(0, 11)]; end
            eop = model_op(r_op, r_fn);
            model_exec(eop, r_a, r_b, eres, ehi, elo, eill);
            apply_stimulus(r_op, r_fn, r_a, r_b, eop, eres, ehi, elo, eill,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                           $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the combinational ALU control decoder. It decodes ALUOp/funct into a 4-bit operation code and executes the operation as a registered execute stage, where the single-cycle ops are AND/OR/ADD/SUB/SLT/NOR. It adds an iterative unsigned multiply/divide unit with HI/LO registers and a valid/ready handshake. The MIPS datapath uses `ready` to stall issue while a multu/divu is in flight.

Parameters:
WIDTH, 32, operand/result/HI/LO width (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_op  in  2  00=add (lw/sw), 01=sub (beq), 10=R-type (decode funct), 11=illegal
funct  in  6  instruction[5:0]
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt
valid  in  1  request present
ready  out  1  unit can accept; a request is accepted on a rising edge where valid&&ready
operation  out  4  combinational decode of current alu_op/funct (codes below)
result  out  WIDTH  registered result
zero  out  1  registered, result==0
result_valid  out  1  one-cycle pulse, result/zero valid this cycle
illegal  out  1  one-cycle pulse, accepted request had undecodable alu_op/funct
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Operation codes:
  - AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, NOR=1100.
  - MULTU=1000, DIVU=1001, MFHI=1010, MFLO=1011, ILLEGAL=1111.
- Decode rules:
  - alu_op 00 gives ADD and 01 gives SUB, regardless of funct.
  - alu_op 10 decodes funct as: 100000/100001 ADD, 100010/100011 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - alu_op 10 also decodes 011001 MULTU, 011011 DIVU, 010000 MFHI, 010010 MFLO.
  - Any other funct, or alu_op 11, decodes to ILLEGAL.
- Reset (async, immediate): state=IDLE, ready=1, result=0, zero=1, result_valid=0, illegal=0, hi=0, lo=0, counter=0. Reset mid-multiply/divide aborts the operation; no pulse is produced.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH with no overflow trap.
  - SLT is a signed compare giving 1 or 0, zero-extended.
  - MFHI/MFLO return the current hi/lo.
- FSM states: IDLE, MUL, DIV.
- IDLE behaviour:
  - ready=1.
  - On accept of a single-cycle op or MFHI/MFLO: at the same edge, result is written and zero updated; result_valid=1 the next cycle (latency 1).
  - On accept of ILLEGAL: result=0, zero=1, illegal=1 and result_valid=1 the next cycle.
  - On accept of MULTU: go to MUL. On accept of DIVU: go to DIV. In both cases latch a/b, clear the counter, and drop ready from the next cycle.
- MUL: shift-add, one bit per cycle, WIDTH cycles. On the edge completing iteration WIDTH, write {hi,lo} = a*b (2*WIDTH-bit product), set result=lo and return to IDLE; result_valid=1 and ready=1 in the following cycle. Accept edge to result_valid is WIDTH+1 cycles.
- DIV: restoring division, WIDTH cycles, same timing as MUL; lo=quotient, hi=remainder, result=lo.
- Divide by zero: no trap; natural restoring result lo=all ones, hi=a, same latency.
- Busy (MUL/DIV): ready=0 and valid is ignored. operation still decodes combinationally. hi/lo hold their old values until the completion edge.
- Back-to-back: a new request may be accepted in the result_valid cycle of the previous one (ready=1 there).
- result and zero hold their value between pulses. result_valid and illegal are never high for more than one consecutive cycle per request.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the ALUOp constants, funct constants and 4-bit operation code constants;
  - the FSM state enum {IDLE, MUL, DIV}.
- Sub-module mdu_iter (WIDTH) holds the shift-add/restoring datapath, counter and {hi,lo} next value. Its interface is start, is_div, a, b, done, hi_out and lo_out.
- The top module keeps the decode, single-cycle ALU, FSM and output registers.

Test Plan:
1. Reset then alu_op=10, funct=100010, a=5, b=5, valid=1 for one cycle -> operation=0110; next cycle result=0, zero=1, result_valid=1 for exactly one cycle.
2. alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1); then a=1, b=0xFFFFFFFF -> result=0, zero=1.
3. MULTU with a=0xFFFFFFFF, b=2 -> ready=0 for 32 cycles, result_valid at accept+33 with hi=1, lo=0xFFFFFFFE, result=0xFFFFFFFE. valid held high during busy -> no extra accept.
4. DIVU with a=100, b=7 -> lo=14, hi=2. DIVU with a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, same latency. Then MFHI -> result=0x1234 after 1 cycle.
5. alu_op=10, funct=000000 -> operation=1111; next cycle illegal=1, result_valid=1, result=0; hi/lo unchanged.
6. MULTU with a=7, b=6; assert rst_n=0 at accept+10 -> immediately ready=1, hi=lo=0, result_valid never pulses. After release, MFLO returns 0.
